// File: rtl/data_bus_mem.sv
// Data-bus slave: byte-lane data RAM plus an MMIO block (LED, switches, timer/compare, bus-error flag).
// Reads return registered data one cycle after the request edge; there is no back-pressure.
module data_bus_mem #(
  parameter int unsigned RAM_WORDS = 1024,
  parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  input  logic [15:0] sw_i,
  output logic [15:0] led_o,
  output logic        irq_o,
  output logic        bus_err_o
);
  localparam int unsigned AW        = $clog2(RAM_WORDS);
  localparam int unsigned RAM_BYTES = 4 * RAM_WORDS;

  localparam logic [3:0] OFF_LED    = 4'd0;
  localparam logic [3:0] OFF_SW     = 4'd1;
  localparam logic [3:0] OFF_TIMER  = 4'd2;
  localparam logic [3:0] OFF_CMP    = 4'd3;
  localparam logic [3:0] OFF_CTRL   = 4'd4;
  localparam logic [3:0] OFF_STATUS = 4'd5;

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  logic [31:0]   mem [RAM_WORDS];
  logic [31:0]   ram_off;
  logic [AW-1:0] ram_idx;
  logic          ram_hit, mmio_hit, unmapped_hit;
  logic [3:0]    reg_off;
  logic          rd_acc, wr_acc;
  logic [31:0]   rd_val;
  logic [31:0]   timer, timer_nxt, cmp, cmp_nxt;
  logic [1:0]    ctrl, ctrl_nxt, status, status_nxt, clr;
  logic [15:0]   led, led_nxt, sw_meta, sw_sync;

  // Address decode; RAM takes priority should the two windows ever overlap
  always_comb begin
    ram_off      = data_addr_i - RAM_BASE;
    ram_hit      = (data_addr_i >= RAM_BASE) && (ram_off < 32'(RAM_BYTES));
    ram_idx      = ram_off[AW+1:2];
    mmio_hit     = !ram_hit && (data_addr_i[31:6] == MMIO_BASE[31:6]);
    unmapped_hit = !ram_hit && !mmio_hit;
    reg_off      = data_addr_i[5:2];
    rd_acc       = data_req_i && !data_we_i;
    wr_acc       = data_req_i && data_we_i;
  end

  // Read mux samples current register values, so TIMER reads are pre-increment
  always_comb begin
    rd_val = '0;
    if (ram_hit) begin
      rd_val = mem[ram_idx];
    end else if (mmio_hit) begin
      case (reg_off)
        OFF_LED:    rd_val = {16'd0, led};
        OFF_SW:     rd_val = {16'd0, sw_sync};
        OFF_TIMER:  rd_val = timer;
        OFF_CMP:    rd_val = cmp;
        OFF_CTRL:   rd_val = {30'd0, ctrl};
        OFF_STATUS: rd_val = {30'd0, status};
        default:    rd_val = '0;
      endcase
    end
  end

  // Register next-state: bus writes override the timer increment, flag sets beat clears
  always_comb begin
    led_nxt   = led;
    timer_nxt = ctrl[0] ? timer + 32'd1 : timer;
    cmp_nxt   = cmp;
    ctrl_nxt  = ctrl;
    clr       = '0;
    if (wr_acc && mmio_hit) begin
      case (reg_off)
        OFF_LED: begin
          if (data_be_i[0]) led_nxt[7:0]  = data_wdata_i[7:0];
          if (data_be_i[1]) led_nxt[15:8] = data_wdata_i[15:8];
        end
        OFF_TIMER:  timer_nxt = lane_merge(timer, data_wdata_i, data_be_i);
        OFF_CMP:    cmp_nxt   = lane_merge(cmp, data_wdata_i, data_be_i);
        OFF_CTRL:   if (data_be_i[0]) ctrl_nxt = data_wdata_i[1:0];
        OFF_STATUS: if (data_be_i[0]) clr = data_wdata_i[1:0];
        default: ;
      endcase
    end
    status_nxt[0] = (ctrl[0] && (timer == cmp)) || (status[0] && !clr[0]);
    status_nxt[1] = (data_req_i && unmapped_hit) || (status[1] && !clr[1]);
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      data_rdata_o <= '0;
      led          <= '0;
      timer        <= '0;
      cmp          <= 32'hFFFF_FFFF;
      ctrl         <= '0;
      status       <= '0;
      irq_o        <= 1'b0;
      sw_meta      <= '0;
      sw_sync      <= '0;
    end else begin
      if (rd_acc) data_rdata_o <= rd_val;
      led     <= led_nxt;
      timer   <= timer_nxt;
      cmp     <= cmp_nxt;
      ctrl    <= ctrl_nxt;
      status  <= status_nxt;
      irq_o   <= status[0] & ctrl[1];
      sw_meta <= sw_i;
      sw_sync <= sw_meta;
    end
  end

  // RAM contents survive reset; reset only blocks a write on an edge it overlaps
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
    end else if (wr_acc && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (data_be_i[i]) mem[ram_idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
      end
    end
  end

  assign led_o     = led;
  assign bus_err_o = status[1];

endmodule

// File: tb/tb_data_bus_mem.sv
// Bench for data_bus_mem: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a word/register-level model of the memory map.
module tb_data_bus_mem;
  localparam int unsigned RAM_WORDS = 1024;

  logic        clk = 1'b0, arstn = 1'b0, req = 1'b0, we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [31:0] rdata;
  logic [15:0] sw = 16'h0, led;
  logic        irq, berr;
  int          total = 0, bad = 0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  data_bus_mem #(.RAM_WORDS(RAM_WORDS)) dut (
    .clk_i(clk), .arstn_i(arstn), .data_req_i(req), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_rdata_o(rdata), .sw_i(sw),
    .led_o(led), .irq_o(irq), .bus_err_o(berr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [RAM_WORDS];
  bit          m_known [RAM_WORDS];
  logic [31:0] m_rdata = 32'h0, m_timer = 32'h0, m_cmp = 32'hFFFF_FFFF;
  bit          m_rd_known = 1'b1;
  logic [15:0] m_led = 16'h0, m_sw1 = 16'h0, m_sw2 = 16'h0;
  bit          m_ten = 1'b0, m_ien = 1'b0, m_match = 1'b0, m_berr = 1'b0, m_irq = 1'b0;

  function automatic logic [31:0] bytes_put(input logic [31:0] old, input logic [31:0] d,
                                            input logic [3:0] b);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic model_step();
    logic [31:0] n_timer, n_cmp, t;
    logic [15:0] n_led;
    bit n_ten, n_ien, clr_m, clr_b, is_ram, is_mmio, hit;
    int w, r;
    is_ram  = addr < 32'(4 * RAM_WORDS);
    is_mmio = (addr >= 32'h8000_0000) && (addr < 32'h8000_0040);
    w = int'(addr >> 2);
    r = int'(addr[5:2]);
    n_timer = m_ten ? m_timer + 32'd1 : m_timer;
    n_cmp = m_cmp; n_led = m_led; n_ten = m_ten; n_ien = m_ien;
    clr_m = 1'b0; clr_b = 1'b0;
    if (req && !we) begin
      m_rd_known = 1'b1;
      if (is_ram) begin
        m_rdata = m_mem[w]; m_rd_known = m_known[w];
      end else if (is_mmio) begin
        case (r)
          0: m_rdata = {16'h0, m_led};
          1: m_rdata = {16'h0, m_sw2};
          2: m_rdata = m_timer;
          3: m_rdata = m_cmp;
          4: m_rdata = {30'h0, m_ien, m_ten};
          5: m_rdata = {30'h0, m_berr, m_match};
          default: m_rdata = 32'h0;
        endcase
      end else m_rdata = 32'h0;
    end
    if (req && we) begin
      if (is_ram) begin
        m_mem[w] = bytes_put(m_mem[w], wdata, be);
        m_known[w] = m_known[w] || (be == 4'hF);
      end else if (is_mmio) begin
        case (r)
          0: begin t = bytes_put({16'h0, m_led}, wdata, {2'b00, be[1:0]}); n_led = t[15:0]; end
          2: n_timer = bytes_put(m_timer, wdata, be);
          3: n_cmp = bytes_put(m_cmp, wdata, be);
          4: if (be[0]) begin n_ten = wdata[0]; n_ien = wdata[1]; end
          5: if (be[0]) begin clr_m = wdata[0]; clr_b = wdata[1]; end
          default: ;
        endcase
      end
    end
    hit = m_ten && (m_timer == m_cmp);
    m_irq   = m_match && m_ien;
    m_match = hit || (m_match && !clr_m);
    m_berr  = (req && !is_ram && !is_mmio) || (m_berr && !clr_b);
    m_sw2 = m_sw1; m_sw1 = sw;
    m_timer = n_timer; m_cmp = n_cmp; m_led = n_led; m_ten = n_ten; m_ien = n_ien;
  endtask

  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      m_rdata = 32'h0; m_rd_known = 1'b1; m_led = 16'h0; m_timer = 32'h0; m_cmp = 32'hFFFF_FFFF;
      m_ten = 1'b0; m_ien = 1'b0; m_match = 1'b0; m_berr = 1'b0; m_irq = 1'b0;
      m_sw1 = 16'h0; m_sw2 = 16'h0;
    end else model_step();
  end

  // Every-cycle comparison shortly after the active edge
  always @(posedge clk) begin
    #1;
    if (chk_en && arstn) begin
      chk("cyc_led", 32'(led), 32'(m_led));
      chk("cyc_irq", 32'(irq), 32'(m_irq));
      chk("cyc_bus_err", 32'(berr), 32'(m_berr));
      if (m_rd_known) chk("cyc_rdata", rdata, m_rdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = r; we = w; be = b; addr = a; wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    drive(1'b1, 1'b1, b, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    drive(1'b1, 1'b0, 4'hF, a, 32'h0);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    rd(a);
    @(negedge clk);
    req = 1'b0;
    chk(name, rdata, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra;
    repeat (3) @(negedge clk);
    #2 arstn = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_bus_err", 32'(berr), 32'h0);
    rd_chk("rst_cmp", 32'h8000_000C, 32'hFFFF_FFFF);

    // RAM byte lanes
    wr(32'h10, 32'h1122_3344, 4'hF);
    wr(32'h10, 32'hAAAA_AAAA, 4'b0100);
    rd_chk("ram_byte_lane", 32'h10, 32'h11AA_3344);

    // Back-to-back reads and hold
    wr(32'h0, 32'hA0A0_0000, 4'hF);
    wr(32'h4, 32'hB1B1_0004, 4'hF);
    rd(32'h0);
    rd(32'h4);
    chk("b2b_word0", rdata, 32'hA0A0_0000);
    idle();
    chk("b2b_word1", rdata, 32'hB1B1_0004);
    idle();
    chk("b2b_hold", rdata, 32'hB1B1_0004);

    // Timer compare and interrupt
    wr(32'h8000_000C, 32'd5, 4'hF);
    wr(32'h8000_0008, 32'd0, 4'hF);
    wr(32'h8000_0010, 32'd3, 4'hF);
    idle();
    for (int k = 0; k < 30 && !irq; k++) @(negedge clk);
    chk("irq_rise", 32'(irq), 32'h1);
    rd_chk("status_match", 32'h8000_0014, 32'h1);
    wr(32'h8000_0014, 32'h1, 4'b0001);
    idle();
    chk("irq_after_clr_edge", 32'(irq), 32'h1);
    idle();
    chk("irq_dropped", 32'(irq), 32'h0);

    // Wrap at all-ones
    wr(32'h8000_0008, 32'hFFFF_FFFF, 4'hF);
    rd(32'h8000_0008);
    rd(32'h8000_0008);
    chk("timer_max", rdata, 32'hFFFF_FFFF);
    idle();
    chk("timer_wrap", rdata, 32'h0);

    // Write beats increment
    wr(32'h8000_0008, 32'h100, 4'hF);
    rd(32'h8000_0008);
    idle();
    chk("timer_write_wins", rdata, 32'h100);

    // Set beats clear: clear issued on the edge where TIMER==CMP
    wr(32'h8000_0014, 32'h3, 4'b0001);
    wr(32'h8000_0008, 32'd3, 4'hF);
    idle();
    idle();
    wr(32'h8000_0014, 32'h1, 4'b0001);
    rd(32'h8000_0014);
    idle();
    chk("status_set_beats_clr", rdata, 32'h1);

    // Unmapped access
    rd_chk("unmapped_rdata", 32'h4000_0000, 32'h0);
    chk("bus_err_set", 32'(berr), 32'h1);
    idle();
    chk("bus_err_sticky", 32'(berr), 32'h1);

    // LED and switch synchroniser
    wr(32'h8000_0000, 32'h0000_BEEF, 4'b0011);
    idle();
    chk("led_write", 32'(led), 32'h0000_BEEF);
    rd(32'h8000_0004);
    sw = 16'h00F0;
    rd(32'h8000_0004);
    chk("sw_edge1", rdata, 32'h0);
    rd(32'h8000_0004);
    chk("sw_edge2", rdata, 32'h0);
    idle();
    chk("sw_synced", rdata, 32'h0000_00F0);

    // Asynchronous reset in the middle of a RAM write
    wr(32'h20, 32'h5555_AAAA, 4'hF);
    wr(32'h20, 32'hDEAD_BEEF, 4'hF);
    #2 arstn = 1'b0;
    #1;
    chk("arst_rdata", rdata, 32'h0);
    chk("arst_led", 32'(led), 32'h0);
    chk("arst_irq", 32'(irq), 32'h0);
    chk("arst_bus_err", 32'(berr), 32'h0);
    @(negedge clk);
    req = 1'b0;
    #2 arstn = 1'b1;
    rd_chk("arst_cmp", 32'h8000_000C, 32'hFFFF_FFFF);
    rd_chk("arst_ram_kept", 32'h20, 32'h5555_AAAA);

    // Randomized traffic, checked every cycle by the model
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      req = ($urandom_range(0, 3) != 0);
      we  = 1'($urandom_range(0, 1));
      be  = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
      case ($urandom_range(0, 7))
        0, 1, 2: ra = 32'($urandom_range(0, 7)) << 2;
        3:       ra = 32'(4 * RAM_WORDS - 4);
        4:       ra = 32'(4 * RAM_WORDS);
        5, 6:    ra = 32'h8000_0000 + (32'($urandom_range(0, 15)) << 2);
        default: ra = $urandom;
      endcase
      addr  = ra | 32'($urandom_range(0, 3));
      wdata = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 12)) : $urandom;
      if ($urandom_range(0, 15) == 0) sw = 16'($urandom);
    end
    idle();
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_bus_mem.md
Name: data_bus_mem

Overview:
- Memory-side slave on the core's data bus; consumes the request/byte-enable/address/wdata stream from the load/store unit and returns `data_rdata`.
- Decodes each access into two regions:
  - on-chip data RAM with byte-lane writes;
  - a small MMIO block: LED output register, synchronised switch input, free-running timer with compare/interrupt, sticky bus-error flag.
- Fixed single-cycle read latency, matching the LSU's one-cycle stall.

Parameters:
- RAM_WORDS, 1024, depth of data RAM in 32-bit words (power of two).
- RAM_BASE, 32'h0000_0000, byte base address of RAM region.
- MMIO_BASE, 32'h8000_0000, byte base address of MMIO region (64-byte window).

Ports:
- clk_i  in  1  system clock, rising edge.
- arstn_i  in  1  reset, asynchronous, active-low.
- data_req_i  in  1  access request, sampled on rising edge.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  4  byte-lane enables for writes (bit n = bits 8n+7:8n).
- data_addr_i  in  32  byte address; bits [1:0] ignored (word access).
- data_wdata_i  in  32  write data, lane-replicated by LSU.
- data_rdata_o  out  32  read data.
- sw_i  in  16  asynchronous switch inputs.
- led_o  out  16  LED register value.
- irq_o  out  1  timer interrupt, level.
- bus_err_o  out  1  sticky unmapped-access flag.

Behaviour:

Reset:
- arstn_i low forces, asynchronously: data_rdata_o=0, led_o=0, TIMER=0, CMP=32'hFFFF_FFFF, CTRL=0, STATUS=0, irq_o=0, bus_err_o=0, switch sync flops=0.
- RAM contents are not reset.
- Reset mid-access aborts the access: no RAM write, rdata=0.

Decode:
- RAM hit: RAM_BASE <= addr < RAM_BASE + 4*RAM_WORDS; word index = (addr - RAM_BASE)[log2(RAM_WORDS)+1:2].
- MMIO hit: addr[31:6] == MMIO_BASE[31:6]; register offset = addr[5:2].
- Anything else is unmapped.

Accept and latency:
- Every edge with data_req_i=1 is one accepted access; no back-pressure.
- Read: data_rdata_o is registered and valid the cycle after the request edge. It holds until the next accepted read; writes and idle cycles do not change it.
- Write: lanes with be=1 update at the request edge; be=0 lanes are untouched; be=4'b0000 is a legal no-op.

MMIO map (word offsets):
- 0x00 LED, RW: bits[15:0] with be[1:0]; reads zero-extended.
- 0x04 SW, RO: {16'd0, sw_sync}. sw_sync is a 2-flop synchroniser of sw_i. Writes ignored.
- 0x08 TIMER, RW, byte-enabled.
  - When CTRL[0]=1, increments by 1 every cycle and wraps 32'hFFFF_FFFF -> 0.
  - A write in the same cycle as an increment wins; the written value appears next cycle, not incremented.
- 0x0C CMP, RW, byte-enabled.
- 0x10 CTRL, RW: bit0 timer enable, bit1 irq enable; other bits read 0.
- 0x14 STATUS:
  - bit0 MATCH: set on any cycle where CTRL[0]=1 and TIMER==CMP.
  - bit1 BUSERR.
  - Write-1-to-clear via be[0]; set beats clear in the same cycle.
- Other offsets: reads 0, writes ignored, not an error.

irq_o and bus_err_o:
- irq_o = registered (STATUS[0] & CTRL[1]), i.e. one cycle after the flag condition.
- Unmapped read returns 32'h0000_0000 next cycle. Any unmapped access sets STATUS[1].
- bus_err_o = STATUS[1].

Reads of TIMER return the pre-increment value sampled at the request edge.

Test Plan:
- RAM byte write: word write 0x11223344 @0x10, then byte write be=4'b0100, wdata=0xAAAAAAAA @0x10, then read @0x10 -> rdata 0x11AA3344 one cycle after request.
- Back-to-back reads: @0x0 then @0x4 on consecutive edges -> rdata shows word0 then word1 on consecutive cycles; a following idle cycle holds word1.
- Timer match:
  - Write CMP=5, TIMER=0, CTRL=3.
  - Expect STATUS[0]=1 and irq_o=1 after TIMER reaches 5.
  - STATUS W1C with be=1 -> irq_o drops one cycle later; TIMER at 32'hFFFF_FFFF wraps to 0.
- Write/increment collision: timer running, write TIMER=0x100 -> next-cycle read returns 0x100 (not 0x101); write STATUS clear on a match cycle -> flag stays 1.
- Unmapped and MMIO I/O:
  - Read @0x4000_0000 -> rdata 0, bus_err_o=1 (sticky).
  - Write LED=0xBEEF -> led_o=0xBEEF.
  - sw_i=0x00F0 -> SW read shows 0x00F0 no earlier than 2 cycles after the change.
- Async reset: assert arstn_i mid-write, between clock edges -> all outputs 0 immediately, CMP reads 0xFFFFFFFF after release, target RAM word unchanged.
